modexp_ctrl: RTL and testbench
==============================

MODEXP_CTRL -- requirements
Module: modexp_ctrl

Interface
REQ-001 Parameter N, default 1024, operand/modulus width in bits.
REQ-002 Parameter EW, default 11, width of exponent-length field (covers 0..N).
REQ-003 clk  input  1  system clock, all state updates on rising edge.
REQ-004 reset  input  1  one clock; reset is synchronous and active-high.
REQ-005 start  input  1  one-cycle request pulse, sampled only in IDLE.
REQ-006 in_x  input  N  base X, normal domain, X < M.
REQ-007 in_e  input  N  exponent E, bit 0 = LSB.
REQ-008 in_e_len  input  EW  number of exponent bits to scan (0..N).
REQ-009 in_m  input  N  odd modulus M.
REQ-010 in_r_mod_m  input  N  R mod M, R = 2^N.
REQ-011 in_r2_mod_m  input  N  R^2 mod M.
REQ-012 result  output  N  X^E mod M, valid from done pulse until next accepted start.
REQ-013 done  output  1  one-cycle completion pulse.
REQ-014 busy  output  1  high from cycle after accepted start through done cycle.
REQ-015 mont_start  output  1  one-cycle start to the Montgomery multiplier.
REQ-016 mont_a, mont_b, mont_m  output  N each  multiplier operands, stable from mont_start until mont_done sampled.
REQ-017 mont_result  input  N  multiplier output, already conditionally reduced (< M).
REQ-018 mont_done  input  1  multiplier completion; may stay high for several cycles.

Function
REQ-019 Algorithm: Xt = MM(X, R^2); A = R mod M; for i = len-1 downto 0 { A = MM(A,A); if E[i] then A = MM(A,Xt) }; result = MM(A,1); MM = Montgomery product.
REQ-020 States: IDLE, TO_MONT, SQUARE, MULT, FROM_MONT, FINISH.
REQ-021 IDLE + start: latch all inputs into internal registers, load A = in_r_mod_m, bit index = in_e_len-1, go TO_MONT.
REQ-022 Each op state asserts mont_start exactly one cycle (first cycle in state), then waits.
REQ-023 mont_done is honoured only after that state's mont_start; first such cycle captures mont_result, later high cycles ignored.
REQ-024 TO_MONT done: Xt <= mont_result; go SQUARE if in_e_len != 0, else FROM_MONT.
REQ-025 SQUARE done: A <= mont_result; go MULT if E[index]=1, else index-decrement path.
REQ-026 MULT done: A <= mont_result; index-decrement path.
REQ-027 Index-decrement path: index 0 -> FROM_MONT, else index-1 and SQUARE.
REQ-028 FROM_MONT (mont_b = 1) done: result <= mont_result, go FINISH.
REQ-029 FINISH: done=1 for one cycle, busy=1, then IDLE.
REQ-030 Op count = 2 + in_e_len + popcount(E[in_e_len-1:0]); total latency = sum of multiplier latencies + 1 cycle per state transition + 1.
REQ-031 start while busy ignored; latched operands unaffected.
REQ-032 in_e_len > N treated as N.
REQ-033 Bits of in_e at or above in_e_len never affect result.

Reset
REQ-034 reset in any state: state IDLE, done 0, busy 0, mont_start 0, result 0, A/Xt/index 0, next cycle.
REQ-035 reset mid-operation abandons the op; stale mont_done after reset ignored (IDLE ignores mont_done).

Structure
REQ-036 Shared package modexp_pkg: state enum, N/EW defaults, constant ONE (N-bit value 1).
REQ-037 Sub-module exp_bit_scanner: holds latched E and index, outputs current bit and last-bit flag, decrements on command.
REQ-038 Montgomery multiplier instantiated beside modexp_ctrl by the parent, not inside.

Verification
REQ-039 X=4, E=13, len=4, M=497 -> result 445, done once, exactly 9 mont_start pulses.
REQ-040 len=0, X=5, M=13 -> result 1, 2 mont_start pulses.
REQ-041 E=all ones, len=1024, random odd 1024-bit M -> result matches reference model, 2050 mont_start pulses.
REQ-042 mont_done held high 5 cycles each op, X=3, E=5, len=3, M=7 -> result 5, each MM captured once.
REQ-043 reset in SQUARE, then start X=2, E=10, len=4, M=1019 -> busy 0 after reset, result 5 after restart.
REQ-044 start pulsed while busy with different operands -> ignored, original result delivered.

Source files
------------

// File: rtl/modexp_pkg.sv
// Shared types and defaults for the modular exponentiation controller.
package modexp_pkg;

    localparam int unsigned N_DEF  = 1024;
    localparam int unsigned EW_DEF = 11;

    // Montgomery-domain exit operand: MM(A, 1) = A * R^-1 mod M
    localparam logic [N_DEF-1:0] ONE = N_DEF'(1);

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_TO_MONT,
        ST_SQUARE,
        ST_MULT,
        ST_FROM_MONT,
        ST_FINISH
    } state_e;

endpackage

// File: rtl/modexp_if.sv
// Request/response and Montgomery-multiplier handshake bundle for modexp_ctrl.
interface modexp_if
    import modexp_pkg::*;
#(
    parameter int unsigned N  = N_DEF,
    parameter int unsigned EW = EW_DEF
);
    logic          start;
    logic [N-1:0]  in_x;
    logic [N-1:0]  in_e;
    logic [EW-1:0] in_e_len;
    logic [N-1:0]  in_m;
    logic [N-1:0]  in_r_mod_m;
    logic [N-1:0]  in_r2_mod_m;
    logic [N-1:0]  result;
    logic          done;
    logic          busy;
    logic          mont_start;
    logic [N-1:0]  mont_a;
    logic [N-1:0]  mont_b;
    logic [N-1:0]  mont_m;
    logic [N-1:0]  mont_result;
    logic          mont_done;

    // Parent side: issues requests and hosts the Montgomery multiplier
    modport master (
        output start, in_x, in_e, in_e_len, in_m, in_r_mod_m, in_r2_mod_m,
        output mont_result, mont_done,
        input  result, done, busy, mont_start, mont_a, mont_b, mont_m
    );

    // Controller side
    modport slave (
        input  start, in_x, in_e, in_e_len, in_m, in_r_mod_m, in_r2_mod_m,
        input  mont_result, mont_done,
        output result, done, busy, mont_start, mont_a, mont_b, mont_m
    );
endinterface

// File: rtl/modexp_ctrl_exp_bit_scanner.sv
// Holds the latched exponent and the current scan index (MSB-first walk).
module exp_bit_scanner #(
    parameter int unsigned N  = 1024,
    parameter int unsigned IW = 10
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          load_i,
    input  logic [N-1:0]  e_i,
    input  logic [IW-1:0] idx_i,
    input  logic          dec_i,
    output logic          cur_bit_c_o,
    output logic          last_c_o
);
    logic [N-1:0]  e_q;
    logic [IW-1:0] idx_q;

    assign cur_bit_c_o = e_q[idx_q];
    assign last_c_o    = (idx_q == '0);

    // Load on accept, step down one bit per decrement command
    always_ff @(posedge clk) begin
        if (reset) begin
            e_q   <= '0;
            idx_q <= '0;
        end else if (load_i) begin
            e_q   <= e_i;
            idx_q <= idx_i;
        end else if (dec_i && (idx_q != '0)) begin
            idx_q <= idx_q - IW'(1);
        end
    end
endmodule

// File: rtl/modexp_ctrl.sv
// Left-to-right Montgomery exponentiation sequencer driving an external multiplier.
module modexp_ctrl
    import modexp_pkg::*;
#(
    parameter int unsigned N  = N_DEF,
    parameter int unsigned EW = EW_DEF
) (
    input logic     clk,
    input logic     reset,
    modexp_if.slave mx
);
    localparam int unsigned IW = (N > 1) ? $clog2(N) : 1;

    state_e        state_q, state_d;
    logic [N-1:0]  x_q, x_d;
    logic [N-1:0]  r2_q, r2_d;
    logic [N-1:0]  m_q, m_d;
    logic [N-1:0]  a_q, a_d;
    logic [N-1:0]  xt_q, xt_d;
    logic          len_nz_q, len_nz_d;
    logic [N-1:0]  result_q, result_d;
    logic          done_q, done_d;
    logic          busy_q, busy_d;
    logic          mont_start_q, mont_start_d;
    logic [N-1:0]  mont_a_q, mont_a_d;
    logic [N-1:0]  mont_b_q, mont_b_d;

    logic [EW-1:0] len_eff_c;
    logic [IW-1:0] idx_ld_c;
    logic          op_state_c;
    logic          cap_c;
    logic          scan_load_c;
    logic          scan_dec_c;
    logic          cur_bit_c;
    logic          last_c;

    // Lengths beyond the operand width scan the full exponent
    assign len_eff_c = (mx.in_e_len > EW'(N)) ? EW'(N) : mx.in_e_len;
    assign idx_ld_c  = (len_eff_c == '0) ? '0 : IW'(len_eff_c - EW'(1));

    // Done is only trusted after the first cycle of an op state, when our start has gone out
    assign op_state_c = (state_q == ST_TO_MONT) || (state_q == ST_SQUARE) ||
                        (state_q == ST_MULT)    || (state_q == ST_FROM_MONT);
    assign cap_c      = op_state_c && !mont_start_q && mx.mont_done;

    exp_bit_scanner #(
        .N  (N),
        .IW (IW)
    ) u_scan (
        .clk         (clk),
        .reset       (reset),
        .load_i      (scan_load_c),
        .e_i         (mx.in_e),
        .idx_i       (idx_ld_c),
        .dec_i       (scan_dec_c),
        .cur_bit_c_o (cur_bit_c),
        .last_c_o    (last_c)
    );

    // Next-state, datapath updates and next multiplier request
    always_comb begin
        state_d      = state_q;
        x_d          = x_q;
        r2_d         = r2_q;
        m_d          = m_q;
        a_d          = a_q;
        xt_d         = xt_q;
        len_nz_d     = len_nz_q;
        result_d     = result_q;
        mont_a_d     = mont_a_q;
        mont_b_d     = mont_b_q;
        mont_start_d = 1'b0;
        scan_load_c  = 1'b0;
        scan_dec_c   = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (mx.start) begin
                    x_d          = mx.in_x;
                    r2_d         = mx.in_r2_mod_m;
                    m_d          = mx.in_m;
                    a_d          = mx.in_r_mod_m;
                    len_nz_d     = (len_eff_c != '0);
                    scan_load_c  = 1'b1;
                    mont_start_d = 1'b1;
                    state_d      = ST_TO_MONT;
                end
            end
            ST_TO_MONT: begin
                if (cap_c) begin
                    xt_d         = mx.mont_result;
                    mont_start_d = 1'b1;
                    state_d      = len_nz_q ? ST_SQUARE : ST_FROM_MONT;
                end
            end
            ST_SQUARE: begin
                if (cap_c) begin
                    a_d          = mx.mont_result;
                    mont_start_d = 1'b1;
                    if (cur_bit_c) begin
                        state_d = ST_MULT;
                    end else if (last_c) begin
                        state_d = ST_FROM_MONT;
                    end else begin
                        scan_dec_c = 1'b1;
                        state_d    = ST_SQUARE;
                    end
                end
            end
            ST_MULT: begin
                if (cap_c) begin
                    a_d          = mx.mont_result;
                    mont_start_d = 1'b1;
                    if (last_c) begin
                        state_d = ST_FROM_MONT;
                    end else begin
                        scan_dec_c = 1'b1;
                        state_d    = ST_SQUARE;
                    end
                end
            end
            ST_FROM_MONT: begin
                if (cap_c) begin
                    result_d = mx.mont_result;
                    state_d  = ST_FINISH;
                end
            end
            ST_FINISH: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        // Operands for the op state being entered, built from the freshly updated values
        if (mont_start_d) begin
            case (state_d)
                ST_TO_MONT: begin
                    mont_a_d = x_d;
                    mont_b_d = r2_d;
                end
                ST_SQUARE: begin
                    mont_a_d = a_d;
                    mont_b_d = a_d;
                end
                ST_MULT: begin
                    mont_a_d = a_d;
                    mont_b_d = xt_d;
                end
                ST_FROM_MONT: begin
                    mont_a_d = a_d;
                    mont_b_d = N'(ONE);
                end
                default: begin
                    mont_a_d = mont_a_q;
                    mont_b_d = mont_b_q;
                end
            endcase
        end

        done_d = (state_d == ST_FINISH);
        busy_d = (state_d != ST_IDLE);
    end

    // State and registered outputs
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= ST_IDLE;
            x_q          <= '0;
            r2_q         <= '0;
            m_q          <= '0;
            a_q          <= '0;
            xt_q         <= '0;
            len_nz_q     <= 1'b0;
            result_q     <= '0;
            done_q       <= 1'b0;
            busy_q       <= 1'b0;
            mont_start_q <= 1'b0;
            mont_a_q     <= '0;
            mont_b_q     <= '0;
        end else begin
            state_q      <= state_d;
            x_q          <= x_d;
            r2_q         <= r2_d;
            m_q          <= m_d;
            a_q          <= a_d;
            xt_q         <= xt_d;
            len_nz_q     <= len_nz_d;
            result_q     <= result_d;
            done_q       <= done_d;
            busy_q       <= busy_d;
            mont_start_q <= mont_start_d;
            mont_a_q     <= mont_a_d;
            mont_b_q     <= mont_b_d;
        end
    end

    assign mx.result     = result_q;
    assign mx.done       = done_q;
    assign mx.busy       = busy_q;
    assign mx.mont_start = mont_start_q;
    assign mx.mont_a     = mont_a_q;
    assign mx.mont_b     = mont_b_q;
    assign mx.mont_m     = m_q;
endmodule

// File: tb/tb_modexp_ctrl.sv
// Directed bench for modexp_ctrl with a behavioural Montgomery multiplier beside it.
module tb_modexp_ctrl;
    import modexp_pkg::*;

    localparam int unsigned N  = 1024;
    localparam int unsigned EW = 11;

    typedef logic [N-1:0] word_t;
    typedef logic [N+1:0] wide_t;

    logic clk = 1'b0;
    logic reset;
    int   checks = 0;
    int   errors = 0;
    int   start_cnt = 0;
    int   done_cnt = 0;
    int   mm_lat = 2;
    int   mm_hold = 1;

    always #5 clk = ~clk;

    modexp_if #(.N(N), .EW(EW)) mif ();

    modexp_ctrl #(.N(N), .EW(EW)) dut (
        .clk   (clk),
        .reset (reset),
        .mx    (mif)
    );

    // Bit-serial Montgomery product a*b*2^-N mod m
    function automatic word_t mont_mul(word_t a, word_t b, word_t m);
        wide_t t = '0;
        for (int i = 0; i < int'(N); i++) begin
            if (b[i]) t = t + wide_t'(a);
            if (t[0]) t = t + wide_t'(m);
            t = t >> 1;
        end
        if (t >= wide_t'(m)) t = t - wide_t'(m);
        return word_t'(t);
    endfunction

    // Plain modular product by shift-and-add
    function automatic word_t mod_mul(word_t a, word_t b, word_t m);
        wide_t r = '0;
        for (int i = int'(N) - 1; i >= 0; i--) begin
            r = r << 1;
            if (r >= wide_t'(m)) r = r - wide_t'(m);
            if (b[i]) r = r + wide_t'(a);
            if (r >= wide_t'(m)) r = r - wide_t'(m);
        end
        return word_t'(r);
    endfunction

    function automatic word_t mod_exp(word_t x, word_t e, int len, word_t m);
        word_t r = word_t'(1);
        for (int i = len - 1; i >= 0; i--) begin
            r = mod_mul(r, r, m);
            if (e[i]) r = mod_mul(r, x, m);
        end
        return r;
    endfunction

    // v * 2^n mod m by repeated doubling
    function automatic word_t mod_dbl(word_t v, word_t m, int n);
        wide_t r = wide_t'(v);
        for (int i = 0; i < n; i++) begin
            r = r << 1;
            if (r >= wide_t'(m)) r = r - wide_t'(m);
        end
        return word_t'(r);
    endfunction

    // Multiplier model: result after mm_lat edges, done held mm_hold cycles or until next start
    initial begin
        logic  st;
        word_t a, b, m, res;
        int    cnt, hcnt;
        mif.mont_done   = 1'b0;
        mif.mont_result = '0;
        cnt  = 0;
        hcnt = 0;
        res  = '0;
        forever begin
            @(posedge clk);
            st = (mif.mont_start === 1'b1);
            a  = mif.mont_a;
            b  = mif.mont_b;
            m  = mif.mont_m;
            #1;
            if (st) begin
                res           = mont_mul(a, b, m);
                mif.mont_done = 1'b0;
                if (mm_lat == 0) begin
                    mif.mont_result = res;
                    mif.mont_done   = 1'b1;
                    hcnt = mm_hold;
                    cnt  = 0;
                end else begin
                    cnt  = mm_lat;
                    hcnt = 0;
                end
            end else if (cnt > 0) begin
                cnt--;
                if (cnt == 0) begin
                    mif.mont_result = res;
                    mif.mont_done   = 1'b1;
                    hcnt = mm_hold;
                end
            end else if (hcnt > 0) begin
                hcnt--;
                if (hcnt == 0) mif.mont_done = 1'b0;
            end
        end
    end

    // Pulse counters
    initial begin
        forever begin
            @(posedge clk);
            if (mif.mont_start === 1'b1) start_cnt++;
            if (mif.done === 1'b1) done_cnt++;
        end
    end

    task automatic chk(input string tag, input word_t obs, input word_t exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h (low 128 bits)", tag, obs[127:0], exp[127:0]);
        end
    endtask

    task automatic drive_req(input word_t x, input word_t e, input logic [EW-1:0] len, input word_t m);
        word_t rm;
        rm = mod_dbl(word_t'(1), m, int'(N));
        mif.in_x        = x;
        mif.in_e        = e;
        mif.in_e_len    = len;
        mif.in_m        = m;
        mif.in_r_mod_m  = rm;
        mif.in_r2_mod_m = mod_dbl(rm, m, int'(N));
        mif.start       = 1'b1;
        @(negedge clk);
        mif.start       = 1'b0;
    endtask

    task automatic wait_done(output logic ok);
        ok = 1'b0;
        for (int i = 0; i < 40000; i++) begin
            @(negedge clk);
            if (mif.done === 1'b1) begin
                ok = 1'b1;
                break;
            end
        end
    endtask

    task automatic run_op(input string tag, input word_t x, input word_t e, input logic [EW-1:0] len,
                          input word_t m, input word_t exp_res, input int exp_starts);
        logic ok;
        int   s0, d0;
        @(negedge clk);
        s0 = start_cnt;
        d0 = done_cnt;
        drive_req(x, e, len, m);
        wait_done(ok);
        chk({tag, "_done_seen"}, word_t'(ok), word_t'(1));
        chk({tag, "_result"}, mif.result, exp_res);
        chk({tag, "_busy_at_done"}, word_t'(mif.busy), word_t'(1));
        repeat (mm_hold + 4) @(negedge clk);
        chk({tag, "_done_pulses"}, word_t'(done_cnt - d0), word_t'(1));
        chk({tag, "_mont_starts"}, word_t'(start_cnt - s0), word_t'(exp_starts));
        chk({tag, "_busy_after"}, word_t'(mif.busy), word_t'(0));
        chk({tag, "_result_held"}, mif.result, exp_res);
    endtask

    initial begin
        word_t e, x, m, ref_res;
        logic  ok;
        int    s0, d0;

        reset           = 1'b1;
        mif.start       = 1'b0;
        mif.in_x        = '0;
        mif.in_e        = '0;
        mif.in_e_len    = '0;
        mif.in_m        = '0;
        mif.in_r_mod_m  = '0;
        mif.in_r2_mod_m = '0;
        repeat (3) @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        chk("rst_busy", word_t'(mif.busy), word_t'(0));
        chk("rst_done", word_t'(mif.done), word_t'(0));
        chk("rst_mont_start", word_t'(mif.mont_start), word_t'(0));
        chk("rst_result", mif.result, word_t'(0));

        // 4^13 mod 497
        mm_lat = 2; mm_hold = 1;
        run_op("basic", word_t'(4), word_t'(13), EW'(4), word_t'(497), word_t'(445), 9);

        // Empty exponent
        run_op("len0", word_t'(5), word_t'(0), EW'(0), word_t'(13), word_t'(1), 2);

        // Multiplier holds done for five cycles
        mm_lat = 1; mm_hold = 5;
        run_op("hold5", word_t'(3), word_t'(5), EW'(3), word_t'(7), word_t'(5), 7);

        // Exponent bits above the scan length must not matter; zero-latency multiplier
        mm_lat = 0; mm_hold = 1;
        e = word_t'(13);
        e[10]  = 1'b1;
        e[600] = 1'b1;
        run_op("hibits", word_t'(4), e, EW'(4), word_t'(497), word_t'(445), 9);

        // Start while busy with different operands is ignored
        mm_lat = 2; mm_hold = 1;
        @(negedge clk);
        s0 = start_cnt;
        d0 = done_cnt;
        drive_req(word_t'(4), word_t'(13), EW'(4), word_t'(497));
        repeat (6) @(negedge clk);
        drive_req(word_t'(7), word_t'(3), EW'(2), word_t'(11));
        wait_done(ok);
        chk("busy_start_done_seen", word_t'(ok), word_t'(1));
        chk("busy_start_result", mif.result, word_t'(445));
        repeat (6) @(negedge clk);
        chk("busy_start_done_pulses", word_t'(done_cnt - d0), word_t'(1));
        chk("busy_start_mont_starts", word_t'(start_cnt - s0), word_t'(9));

        // Reset during the first squaring, then a fresh operation
        mm_lat = 3; mm_hold = 1;
        @(negedge clk);
        s0 = start_cnt;
        drive_req(word_t'(4), word_t'(13), EW'(4), word_t'(497));
        ok = 1'b0;
        for (int i = 0; i < 200; i++) begin
            if (start_cnt - s0 >= 2) begin
                ok = 1'b1;
                break;
            end
            @(negedge clk);
        end
        chk("rst_mid_reached_square", word_t'(ok), word_t'(1));
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        chk("rst_mid_busy", word_t'(mif.busy), word_t'(0));
        chk("rst_mid_done", word_t'(mif.done), word_t'(0));
        chk("rst_mid_mont_start", word_t'(mif.mont_start), word_t'(0));
        chk("rst_mid_result", mif.result, word_t'(0));
        d0 = done_cnt;
        s0 = start_cnt;
        repeat (10) @(negedge clk);
        chk("rst_stale_done_ignored", word_t'(done_cnt - d0), word_t'(0));
        chk("rst_stale_no_start", word_t'(start_cnt - s0), word_t'(0));
        chk("rst_stale_busy", word_t'(mif.busy), word_t'(0));
        run_op("after_rst", word_t'(2), word_t'(10), EW'(4), word_t'(1019), word_t'(5), 8);

        // Scan length beyond N is clamped to N
        mm_lat = 1; mm_hold = 1;
        run_op("len_clamp", word_t'(5), word_t'(1), EW'(2047), word_t'(497), word_t'(5), 1027);

        // Full-width all-ones exponent with a random odd modulus
        mm_lat = 1; mm_hold = 2;
        for (int w = 0; w < int'(N) / 32; w++) begin
            m[w*32 +: 32] = $urandom;
            x[w*32 +: 32] = $urandom;
        end
        m[N-1] = 1'b1;
        m[0]   = 1'b1;
        x[N-1] = 1'b0;
        e      = '1;
        ref_res = mod_exp(x, e, int'(N), m);
        run_op("full1024", x, e, EW'(N), m, ref_res, 2050);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
